// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_ctrl
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//            controller. Load hits return data combinationally; load misses
//            refill the whole block one word at a time; stores always go to
//            main memory and update the cached word only on a hit.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            MemRead/MemWrite   - load / store request from the decoder
//            addr, wdata        - byte address and store data from the core
//            rdata, stall       - load data and pipeline freeze
//            mem_rd_req/wr_req  - main-memory word read / write request
//            mem_addr/mem_wdata - main-memory word address and write data
//            mem_rdata/ready    - main-memory read data and completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [OFF_W-1:0]  r_cnt;
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [NUM_BLOCKS];
  logic [31:0]       r_data [NUM_BLOCKS][BLOCK_WORDS];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_last;
  logic              w_stall;
  logic              w_cnt_clr;
  logic              w_refill_we;
  logic              w_store_we;
  logic              w_unused_addr_bits;

  assign w_off  = addr[2 +: OFF_W];
  assign w_idx  = addr[2 + OFF_W +: IDX_W];
  assign w_tag  = addr[ADDR_W-1 -: TAG_W];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last = (r_cnt == OFF_W'(BLOCK_WORDS - 1));

  // Byte-lane and upper address bits are outside the cached address space.
  assign w_unused_addr_bits = ^{addr[31:ADDR_W], addr[1:0]};

  // Hit data is presented in every state; outside IDLE the core is stalled
  // and ignores it.
  assign rdata = w_hit ? r_data[w_idx][w_off] : 32'd0;

  // Stall is derived partly from the core inputs, so it is gated by reset to
  // stay low while rst_n is asserted.
  assign stall = w_stall & rst_n;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    w_cnt_clr   = 1'b0;
    w_refill_we = 1'b0;
    w_store_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemWrite) begin
          w_stall     = 1'b1;
          w_state_nxt = WRITE;
        end else if (MemRead && !w_hit) begin
          w_stall     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = REFILL;
        end
      end
      REFILL: begin
        // The core holds addr while stalled, so tag/index stay stable
        // across the whole refill.
        w_stall    = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = {w_tag, w_idx, r_cnt, 2'b00};
        if (mem_ready) begin
          w_refill_we = 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
          end
        end
      end
      WRITE: begin
        w_stall    = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = {addr[ADDR_W-1:2], 2'b00};
        mem_wdata  = wdata;
        if (mem_ready) begin
          w_store_we  = w_hit;
          w_state_nxt = WDONE;
        end
      end
      WDONE: begin
        // One unstalled cycle lets the store retire before IDLE would see
        // the same MemWrite again.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
        // The block is overwritten word by word, so it must not hit until
        // the refill completes.
        r_valid[w_idx] <= 1'b0;
      end else if (w_refill_we) begin
        if (w_last) begin
          r_cnt          <= '0;
          r_valid[w_idx] <= 1'b1;
        end else begin
          r_cnt <= r_cnt + OFF_W'(1);
        end
      end
    end
  end

  // Data and tag storage carry no reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (w_refill_we) begin
      r_data[w_idx][r_cnt] <= mem_rdata;
      if (w_last) begin
        r_tag[w_idx] <= w_tag;
      end
    end
    if (w_store_we) begin
      r_data[w_idx][w_off] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_ctrl
// Purpose  : Self-checking bench for data_cache_ctrl with a main-memory
//            responder of programmable latency. Single-cycle behaviour is
//            checked from a vector table; refills, stores and reset aborts
//            are checked by hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        r_rdy;
  logic        stray;
  logic [31:0] mem [0:255];
  int          mem_lat;
  int          lat_cnt;
  logic [9:0]  rd_log [$];
  logic [9:0]  wr_log [$];
  int          both_cnt;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  assign mem_ready = r_rdy | stray;

  data_cache_ctrl #(
    .ADDR_W      (10),
    .NUM_BLOCKS  (8),
    .BLOCK_WORDS (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  // Main-memory model: answers a request mem_lat cycles after it is first
  // seen, with a one-cycle ready pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy   <= 1'b0;
      lat_cnt <= 0;
    end else if (r_rdy) begin
      r_rdy   <= 1'b0;
      lat_cnt <= 0;
    end else if (mem_rd_req || mem_wr_req) begin
      if (lat_cnt >= mem_lat - 1) begin
        r_rdy   <= 1'b1;
        lat_cnt <= 0;
        if (mem_rd_req) begin
          mem_rdata <= mem[mem_addr[9:2]];
          rd_log.push_back(mem_addr);
        end
        if (mem_wr_req) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          wr_log.push_back(mem_addr);
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (mem_rd_req && mem_wr_req) both_cnt++;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] exp_rdata;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle vectors in IDLE; requests are withdrawn before the next edge.
  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      MemRead  = vecs[i].rd;
      MemWrite = vecs[i].wr;
      addr     = vecs[i].a;
      wdata    = 32'h0BAD_F00D;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_rdreq", i), {31'd0, mem_rd_req}, 32'd0);
      check($sformatf("vec%0d_wrreq", i), {31'd0, mem_wr_req}, 32'd0);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input int exp_reads);
    int         cyc;
    logic [9:0] ea;
    rd_log.delete();
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = a;
    #1;
    check($sformatf("ld%h_stall_first", a[9:0]), {31'd0, stall}, (exp_reads != 0) ? 32'd1 : 32'd0);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check($sformatf("ld%h_stall_end", a[9:0]), {31'd0, stall}, 32'd0);
    check($sformatf("ld%h_rdata", a[9:0]), rdata, exp);
    check($sformatf("ld%h_nreads", a[9:0]), rd_log.size(), exp_reads);
    for (int i = 0; i < rd_log.size() && i < 4; i++) begin
      ea = {a[9:4], 2'(i), 2'b00};
      check($sformatf("ld%h_raddr%0d", a[9:0], i), {22'd0, rd_log[i]}, {22'd0, ea});
    end
    MemRead = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int cyc;
    wr_log.delete();
    @(negedge clk);
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    addr     = a;
    wdata    = d;
    #1;
    check($sformatf("st%h_stall_first", a[9:0]), {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check($sformatf("st%h_wrreq", a[9:0]), {31'd0, mem_wr_req}, 32'd1);
    check($sformatf("st%h_rdreq", a[9:0]), {31'd0, mem_rd_req}, 32'd0);
    check($sformatf("st%h_maddr", a[9:0]), {22'd0, mem_addr}, {22'd0, a[9:2], 2'b00});
    check($sformatf("st%h_mwdata", a[9:0]), mem_wdata, d);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check($sformatf("st%h_wdone_stall", a[9:0]), {31'd0, stall}, 32'd0);
    check($sformatf("st%h_wdone_wrreq", a[9:0]), {31'd0, mem_wr_req}, 32'd0);
    check($sformatf("st%h_nwrites", a[9:0]), wr_log.size(), 32'd1);
    check($sformatf("st%h_memword", a[9:0]), mem[a[9:2]], d);
    MemWrite = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_rdreq"}, {31'd0, mem_rd_req}, 32'd0);
    check({tag, "_wrreq"}, {31'd0, mem_wr_req}, 32'd0);
    check({tag, "_maddr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int cyc;
    n_tests   = 0;
    n_fail    = 0;
    both_cnt  = 0;
    stray     = 1'b0;
    mem_lat   = 3;
    mem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[16] = 32'h11; mem[17] = 32'h22; mem[18] = 32'h33; mem[19] = 32'h44;
    mem[48] = 32'hA0; mem[49] = 32'hA1; mem[50] = 32'hA2; mem[51] = 32'hA3;

    //             rd    wr    addr          rdata          stall
    vecs[0]  = '{1'b1, 1'b0, 32'h048, 32'h33,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h04C, 32'h44,         1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h040, 32'h11,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h044, 32'h22,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h140, 32'h0,          1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h140, 32'h0,          1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h040, 32'h11,         1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h200, 32'h0,          1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h044, 32'hDEAD_BEEF,  1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h044, 32'hDEAD_BEEF,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h3C0, 32'h0,          1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h040, 32'h11,         1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h04C, 32'h44,         1'b0};

    // Reset with a load pending: every output must still be zero.
    rst_n    = 1'b0;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = 32'h040;
    wdata    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cold load, latency 3, then single-cycle hits and request decode.
    do_load(32'h040, 32'h11, 4);
    apply_vecs(0, 7);

    // Store hit updates cache and memory; reload must not refill.
    mem_lat = 2;
    do_store(32'h044, 32'hDEAD_BEEF);
    apply_vecs(8, 9);
    do_load(32'h044, 32'hDEAD_BEEF, 0);

    // Store miss: memory written, resident block for index 4 untouched.
    mem_lat = 1;
    do_store(32'h3C0, 32'h1234_5678);
    apply_vecs(10, 12);
    do_load(32'h3C0, 32'h1234_5678, 4);

    // Conflicts within index 4.
    do_load(32'h040, 32'h11, 4);
    do_load(32'h044, 32'hDEAD_BEEF, 0);
    do_load(32'h0C0, 32'hA0, 4);
    do_load(32'h040, 32'h11, 4);

    // Reset two words into a refill.
    mem_lat = 2;
    rd_log.delete();
    @(negedge clk);
    MemRead = 1'b1;
    addr    = 32'h100;
    cyc     = 0;
    while (rd_log.size() < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_two_reads", rd_log.size(), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // A stray ready with nothing outstanding must be ignored.
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    #1;
    check("stray_stall", {31'd0, stall}, 32'd0);
    check("stray_rdreq", {31'd0, mem_rd_req}, 32'd0);
    check("stray_wrreq", {31'd0, mem_wr_req}, 32'd0);
    check("stray_rdata_partial", rdata, 32'd0);
    addr = 32'h040;
    #1;
    check("postrst_invalid_040", rdata, 32'd0);
    do_load(32'h100, 32'hC0DE_0040, 4);

    check("rd_wr_overlap", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, byte-address bits used; NUM_BLOCKS, 8, direct-mapped blocks; BLOCK_WORDS, 4, 32-bit words per block.
REQ-002 Ports SHALL be exactly (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load or fLW request from the main decoder.
- MemWrite  in  1  store or fSW request from the main decoder.
- addr  in  32  byte address from the ALU; only addr[ADDR_W-1:2] is used.
- wdata  in  32  store data, integer or FP register.
- rdata  out  32  load data to the result mux.
- stall  out  1  freezes PC and register-file writes while high.
- mem_rd_req  out  1  main-memory word read request.
- mem_wr_req  out  1  main-memory word write request.
- mem_addr  out  ADDR_W  main-memory byte address, word aligned.
- mem_wdata  out  32  main-memory write data.
- mem_rdata  in  32  main-memory read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse for the current request.
REQ-003 Reset SHALL be asynchronous on rst_n low, and all other logic SHALL be synchronous to rising clk.

Function
REQ-004 Address split SHALL be: offset = addr[3:2], index = addr[6:4], tag = addr[9:7].
- Storage SHALL be a data array of 8x4x32 bits, a tag array of 8x3 bits and 8 valid bits.
REQ-005 Policy SHALL be write-through with no write-allocate, and read misses SHALL refill the whole block.
REQ-006 The FSM SHALL have exactly the states IDLE, REFILL, WRITE and WDONE.
REQ-007 In IDLE with MemRead=1 and MemWrite=0 on a hit (valid and tag match):
- rdata SHALL be the data word, combinational, in the same cycle.
- stall SHALL be 0 and the state SHALL remain IDLE.
REQ-008 In IDLE with MemRead=1 on a miss:
- stall SHALL be 1 combinationally in the same cycle.
- The next state SHALL be REFILL, and the word counter SHALL clear to 0.
REQ-009 In REFILL:
- stall=1 and mem_rd_req=1.
- mem_addr = {tag, index, counter, 2'b00}.
- On each mem_ready, mem_rdata SHALL be written to word[counter] and the counter SHALL increment.
REQ-010 On mem_ready with counter=3:
- The block's tag SHALL be set and its valid bit set.
- The counter SHALL wrap to 0 and the state SHALL return to IDLE.
- The held load then hits per REQ-007, so total miss penalty = 4 memory transactions + 1 cycle.
REQ-011 In IDLE with MemWrite=1, stall SHALL be 1 and the next state SHALL be WRITE; MemWrite SHALL take priority if MemRead is also 1.
REQ-012 In WRITE:
- stall=1, mem_wr_req=1, mem_addr={addr[9:2],2'b00}, mem_wdata=wdata.
- On mem_ready, if the address hits, the cached word SHALL be updated with wdata.
- On mem_ready, the state SHALL go to WDONE.
REQ-013 In WDONE, stall SHALL be 0 for exactly one cycle so the store retires, and the next state SHALL be IDLE.
REQ-014 Memory handshake: the req signal, mem_addr and mem_wdata SHALL stay stable from assertion until the mem_ready cycle inclusive.
- mem_rd_req and mem_wr_req SHALL never be 1 together.
- mem_ready arriving while no request is active SHALL be ignored.
REQ-015 When MemRead=0 and MemWrite=0 in IDLE, stall=0, no request SHALL be issued and no state SHALL change.
- rdata SHALL then show the addressed word if hit, otherwise 0.
REQ-016 Any memory latency of 1 or more cycles SHALL be tolerated, and the block SHALL never time out.

Reset
REQ-017 rst_n low SHALL immediately force:
- state=IDLE and counter=0;
- all valid bits=0;
- stall=0, mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-018 Reset asserted mid-REFILL or mid-WRITE SHALL abort the transaction.
- The partial block SHALL stay invalid.
- mem_ready pulses after reset release SHALL be ignored until a new request is issued.
REQ-019 Data and tag arrays need no reset; only the valid bits SHALL gate hits.

Verification
REQ-020 Bench SHALL cover:
- Cold load: reset, then MemRead addr=0x040, memory holding 0x11,0x22,0x33,0x44 at 0x040-0x04C, latency 3 -> stall high, 4 reads at 0x040,0x044,0x048,0x04C, then rdata=0x11 with stall=0.
- Hit after refill: MemRead addr=0x048 -> rdata=0x33 in the same cycle, stall=0, no mem_rd_req.
- Store hit: MemWrite addr=0x044 wdata=0xDEADBEEF -> mem_wr_req to 0x044, one WDONE cycle with stall=0; then load 0x044 -> 0xDEADBEEF with no refill.
- Store miss: MemWrite addr=0x3C0 -> memory written, valid bits unchanged; load 0x3C0 -> refill occurs.
- Conflict: load 0x040, then load 0x0C0 (same index, tag differs) -> refill replaces the block; reload of 0x040 misses again.
- Reset mid-refill after 2 words -> all outputs 0; reload of the same address performs a full 4-word refill.
